// File: rtl/bias_seq_ctrl.sv
// Bandgap / bias sequencer: startup pulse, settle wait, retried fault handling,
// inrush-limited channel grant and shadowed trim application.
module bias_seq_ctrl #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned TRIM_W      = 5,
   parameter int unsigned STARTUP_CYC = 16,
   parameter int unsigned SETTLE_CYC  = 64,
   parameter int unsigned MAX_RETRY   = 2
) (
   input  logic              CLK_I,
   input  logic              RSTN_I,
   input  logic              EN_I,
   input  logic [NCH-1:0]    CH_EN_I,
   input  logic              EN_VBIAS_I,
   input  logic [TRIM_W-1:0] TRIM_VBG_I,
   input  logic [TRIM_W-1:0] TRIM_CURV_I,
   input  logic [3:0]        TRIM_BIAS_I,
   input  logic              TRIM_LD_I,
   input  logic              BG_VALID_N_I,
   output logic              BG_EN_O,
   output logic              BG_STARTUP_O,
   output logic              EN_VBIAS_O,
   output logic [TRIM_W-1:0] TRIM_VBG_O,
   output logic [TRIM_W-1:0] TRIM_CURV_O,
   output logic [3:0]        TRIM_BIAS_O,
   output logic [NCH-1:0]    CH_EN_O,
   output logic              READY_O,
   output logic              FAULT_O
);

   localparam int unsigned MAX_CYC = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
   localparam int unsigned RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {
      S_OFF, S_STARTUP, S_SETTLE, S_READY, S_RETRIM, S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RTY_W-1:0]  retry_q, retry_d;
   logic [TRIM_W-1:0] vbg_q, vbg_d, curv_q, curv_d;
   logic [3:0]        bias_q, bias_d;
   logic [1:0]        sync_q;
   logic              valid;
   logic              fault_path;
   logic [NCH-1:0]    pend, grant, ch_d;
   logic              bg_en_d, startup_d, vbias_d, ready_d, fault_d;
   logic [TRIM_W-1:0] vbg_o_d, curv_o_d;
   logic [3:0]        bias_o_d;

   // Analog valid flag resynchronised; idles at "not valid".
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) sync_q <= 2'b11;
      else         sync_q <= {sync_q[0], BG_VALID_N_I};
   end

   assign valid = ~sync_q[1];

   // Next state, counters, shadow trims and next registered outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      retry_d    = retry_q;
      vbg_d      = vbg_q;
      curv_d     = curv_q;
      bias_d     = bias_q;
      ch_d       = '0;
      fault_path = 1'b0;
      pend       = CH_EN_I & ~CH_EN_O;
      grant      = pend & (~pend + NCH'(1));

      unique case (state_q)
         S_OFF: begin
            cnt_d   = '0;
            retry_d = '0;
            if (EN_I) begin
               vbg_d   = TRIM_VBG_I;
               curv_d  = TRIM_CURV_I;
               bias_d  = TRIM_BIAS_I;
               state_d = S_STARTUP;
            end
         end
         S_STARTUP: begin
            if (cnt_q == CNT_W'(STARTUP_CYC - 1)) begin
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               cnt_d = '0;
               if (valid) begin
                  retry_d = '0;
                  state_d = S_READY;
               end else begin
                  fault_path = 1'b1;
               end
            end
         end
         S_READY: begin
            cnt_d = '0;
            if (!valid) begin
               fault_path = 1'b1;
            end else if (TRIM_LD_I) begin
               vbg_d   = TRIM_VBG_I;
               curv_d  = TRIM_CURV_I;
               bias_d  = TRIM_BIAS_I;
               state_d = S_RETRIM;
            end else begin
               // Drop released channels at once, add at most one new one per cycle.
               ch_d = (CH_EN_O & CH_EN_I) | grant;
            end
         end
         S_RETRIM: begin
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
         S_FAULT: cnt_d = '0;
         default: begin
            cnt_d   = '0;
            state_d = S_OFF;
         end
      endcase

      if (fault_path) begin
         cnt_d = '0;
         if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_STARTUP;
         end else begin
            state_d = S_FAULT;
         end
      end

      // Disable wins over every other transition.
      if (!EN_I) begin
         state_d = S_OFF;
         cnt_d   = '0;
         retry_d = '0;
         ch_d    = '0;
      end

      bg_en_d   = (state_d != S_OFF);
      startup_d = (state_d == S_STARTUP);
      ready_d   = (state_d == S_READY);
      fault_d   = (state_d == S_FAULT);
      vbias_d   = (state_d == S_READY) & EN_VBIAS_I;
      vbg_o_d   = (state_d == S_OFF) ? '0 : vbg_d;
      curv_o_d  = (state_d == S_OFF) ? '0 : curv_d;
      bias_o_d  = (state_d == S_OFF) ? '0 : bias_d;
   end

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         state_q      <= S_OFF;
         cnt_q        <= '0;
         retry_q      <= '0;
         vbg_q        <= '0;
         curv_q       <= '0;
         bias_q       <= '0;
         BG_EN_O      <= 1'b0;
         BG_STARTUP_O <= 1'b0;
         EN_VBIAS_O   <= 1'b0;
         TRIM_VBG_O   <= '0;
         TRIM_CURV_O  <= '0;
         TRIM_BIAS_O  <= '0;
         CH_EN_O      <= '0;
         READY_O      <= 1'b0;
         FAULT_O      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         vbg_q        <= vbg_d;
         curv_q       <= curv_d;
         bias_q       <= bias_d;
         BG_EN_O      <= bg_en_d;
         BG_STARTUP_O <= startup_d;
         EN_VBIAS_O   <= vbias_d;
         TRIM_VBG_O   <= vbg_o_d;
         TRIM_CURV_O  <= curv_o_d;
         TRIM_BIAS_O  <= bias_o_d;
         CH_EN_O      <= ch_d;
         READY_O      <= ready_d;
         FAULT_O      <= fault_d;
      end
   end

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Scoreboard bench for bias_seq_ctrl: a phase/countdown reference model queues the
// expected outputs per clock edge, an independent monitor pops and compares them.
module tb_bias_seq_ctrl;

   localparam int NCH = 4;
   localparam int TW  = 5;
   localparam int SU  = 16;
   localparam int ST  = 64;
   localparam int MR  = 2;
   localparam int OW  = 3 + 2 * TW + 4 + NCH + 2;

   localparam int PH_OFF = 0, PH_STARTUP = 1, PH_SETTLE = 2, PH_READY = 3,
                  PH_RETRIM = 4, PH_FAULT = 5;

   logic clk = 1'b0;
   logic rst_n, en, vbias_req, trim_ld, bg_valid_n;
   logic [NCH-1:0] ch_req;
   logic [TW-1:0]  trim_vbg, trim_curv;
   logic [3:0]     trim_bias;
   logic bg_en, bg_startup, vbias_en, ready, fault;
   logic [TW-1:0]  vbg_o, curv_o;
   logic [3:0]     bias_o;
   logic [NCH-1:0] ch_o;
   logic [OW-1:0]  dut_vec;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bias_seq_ctrl #(.NCH(NCH), .TRIM_W(TW), .STARTUP_CYC(SU), .SETTLE_CYC(ST), .MAX_RETRY(MR)) dut (
      .CLK_I(clk), .RSTN_I(rst_n), .EN_I(en), .CH_EN_I(ch_req), .EN_VBIAS_I(vbias_req),
      .TRIM_VBG_I(trim_vbg), .TRIM_CURV_I(trim_curv), .TRIM_BIAS_I(trim_bias),
      .TRIM_LD_I(trim_ld), .BG_VALID_N_I(bg_valid_n),
      .BG_EN_O(bg_en), .BG_STARTUP_O(bg_startup), .EN_VBIAS_O(vbias_en),
      .TRIM_VBG_O(vbg_o), .TRIM_CURV_O(curv_o), .TRIM_BIAS_O(bias_o),
      .CH_EN_O(ch_o), .READY_O(ready), .FAULT_O(fault)
   );

   assign dut_vec = {bg_en, bg_startup, vbias_en, vbg_o, curv_o, bias_o, ch_o, ready, fault};

   typedef struct {
      int            cyc;
      logic [OW-1:0] vec;
   } exp_t;
   exp_t sb[$];

   // Reference model: phase plus cycles remaining in it.
   int m_phase = PH_OFF, m_left = 0, m_retry = 0;
   logic [TW-1:0]  m_vbg = '0, m_curv = '0;
   logic [3:0]     m_bias = '0;
   logic [NCH-1:0] m_ch = '0;
   logic m_vbias = 1'b0, m_vn1 = 1'b1, m_vn2 = 1'b1;

   task automatic model_edge();
      logic v, fp, found;
      logic [NCH-1:0] nch;
      if (!rst_n) begin
         m_phase = PH_OFF; m_left = 0; m_retry = 0;
         m_vbg = '0; m_curv = '0; m_bias = '0; m_ch = '0; m_vbias = 1'b0;
         m_vn1 = 1'b1; m_vn2 = 1'b1;
         return;
      end
      // Valid seen at this edge is the flag sampled two edges earlier.
      v = !m_vn2;
      m_vn2 = m_vn1;
      m_vn1 = bg_valid_n;
      fp = 1'b0;
      nch = '0;
      if (!en) begin
         m_phase = PH_OFF;
         m_retry = 0;
      end else begin
         case (m_phase)
            PH_OFF: begin
               m_vbg = trim_vbg; m_curv = trim_curv; m_bias = trim_bias;
               m_phase = PH_STARTUP; m_left = SU;
            end
            PH_STARTUP: if (m_left == 1) begin m_phase = PH_SETTLE; m_left = ST; end
                        else m_left--;
            PH_SETTLE: if (m_left == 1) begin
                          if (v) begin m_phase = PH_READY; m_retry = 0; end
                          else fp = 1'b1;
                       end else m_left--;
            PH_READY: if (!v) fp = 1'b1;
                      else if (trim_ld) begin
                         m_vbg = trim_vbg; m_curv = trim_curv; m_bias = trim_bias;
                         m_phase = PH_RETRIM;
                      end else begin
                         nch = m_ch & ch_req;
                         found = 1'b0;
                         for (int i = 0; i < NCH; i++)
                            if (!found && ch_req[i] && !nch[i]) begin nch[i] = 1'b1; found = 1'b1; end
                      end
            PH_RETRIM: begin m_phase = PH_SETTLE; m_left = ST; end
            default: ;
         endcase
         if (fp) begin
            if (m_retry < MR) begin m_retry++; m_phase = PH_STARTUP; m_left = SU; end
            else m_phase = PH_FAULT;
         end
      end
      m_ch = nch;
      m_vbias = (m_phase == PH_READY) && vbias_req;
   endtask

   function automatic logic [OW-1:0] model_out();
      logic on;
      on = (m_phase != PH_OFF);
      return {on, m_phase == PH_STARTUP, m_vbias,
              on ? m_vbg : {TW{1'b0}}, on ? m_curv : {TW{1'b0}}, on ? m_bias : 4'd0,
              m_ch, m_phase == PH_READY, m_phase == PH_FAULT};
   endfunction

   // Commit the currently driven inputs for the next edge, then move past it.
   task automatic tick();
      exp_t e;
      model_edge();
      e.cyc = cyc + 1;
      e.vec = model_out();
      sb.push_back(e);
      @(posedge clk);
      #4;
      trim_ld = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_vec(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Monitor: compares every edge's outputs with the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++; errors++;
            $display("FAIL stale expectation for cycle %0d at cycle %0d", e.cyc, cyc);
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if (dut_vec !== e.vec) begin
               errors++;
               $display("FAIL outputs cycle %0d: got %h expected %h", cyc, dut_vec, e.vec);
            end
         end
      end
   end

   initial begin
      int glitch;
      rst_n = 1'b0; en = 1'b0; ch_req = '0; vbias_req = 1'b0; trim_ld = 1'b0;
      trim_vbg = '0; trim_curv = '0; trim_bias = '0; bg_valid_n = 1'b1;
      #1;
      check_vec("reset outputs", dut_vec, '0);
      ticks(3);
      rst_n = 1'b1;
      ticks(2);

      // Power-up with valid bandgap, then inrush-limited channel grant.
      bg_valid_n = 1'b0; vbias_req = 1'b1;
      trim_vbg = 5'($urandom); trim_curv = 5'($urandom); trim_bias = 4'($urandom);
      en = 1'b1;
      tick();
      trim_vbg = 5'($urandom); trim_curv = 5'($urandom);
      ticks(85);
      ch_req = 4'b1111;
      ticks(6);
      ch_req = 4'b0000;
      ticks(2);
      ch_req = 4'b1011;
      ticks(4);

      // Retrim from READY.
      trim_vbg = 5'h13; trim_ld = 1'b1;
      tick();
      check_vec("retrim vbg/ready/ch", {vbg_o, ready, ch_o}, {5'h13, 1'b0, 4'b0000});
      ticks(70);

      // Randomised operation with valid glitches, retrims and disables.
      glitch = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(3) == 0) ch_req = 4'($urandom);
         vbias_req = 1'($urandom);
         trim_vbg = 5'($urandom); trim_curv = 5'($urandom); trim_bias = 4'($urandom);
         trim_ld = ($urandom_range(24) == 0);
         if (glitch > 0) glitch--;
         else if ($urandom_range(119) == 0) glitch = $urandom_range(1, 3);
         bg_valid_n = (glitch > 0);
         en = ($urandom_range(199) != 0);
         tick();
      end

      // Bandgap never valid: retries exhausted, fault, then disable.
      en = 1'b0; bg_valid_n = 1'b1; trim_ld = 1'b0;
      ticks(3);
      en = 1'b1;
      ticks(3 * (SU + ST) + 10);
      en = 1'b0;
      ticks(3);

      // Asynchronous reset mid-settle.
      bg_valid_n = 1'b0; en = 1'b1;
      ticks(SU + 30);
      rst_n = 1'b0;
      #1;
      check_vec("async reset outputs", dut_vec, '0);
      ticks(2);
      rst_n = 1'b1;
      ticks(SU + ST + 10);

      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
